// File: rtl/ui_pkg.sv
// Shared types and helpers for the UI button conditioner.
// The FSM encoding depends on UI_AUTOREPEAT_EN (auto-repeat states only when defined).
package ui_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;

`ifdef UI_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } btn_state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } btn_state_t;
`endif

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ui_btn_channel.sv
// One button: 2-FF synchroniser, debounce, press/release pulses and repeat FSM.
// Auto-repeat logic exists only when UI_AUTOREPEAT_EN is defined.
module ui_btn_channel
  import ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
    $error("ui_btn_channel: need DEBOUNCE_CYCLES >= 2 and nonzero repeat timing");
  end

  logic [1:0]      sync_q;
  logic            s;
  logic [DB_W-1:0] db_cnt;
  logic            toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[0], button};
  end

  assign s      = ~sync_q[1];
  assign toggle = (s != level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level         <= 1'b0;
      db_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= toggle && !level;
      release_pulse <= toggle && level;
      if (toggle) level <= ~level;
      if (s == level || toggle) db_cnt <= '0;
      else                      db_cnt <= db_cnt + DB_W'(1);
    end
  end

`ifdef UI_AUTOREPEAT_EN
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = cnt_width(RP_MAX);

  btn_state_t      state_q, state_d;
  logic [RP_W-1:0] rcnt_q, rcnt_d;
  logic            rpt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rcnt_q       <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      repeat_pulse <= rpt_d;
    end
  end

  // rcnt counts cycles spent in the current state; the pulse is registered so it
  // lands exactly REPEAT_DELAY / REPEAT_PERIOD cycles after the reference cycle.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (toggle && !level) begin
          state_d = ST_HOLD;
          rcnt_d  = '0;
        end
      end
      ST_HOLD: begin
        if (rcnt_q == RP_W'(REPEAT_DELAY - 1)) begin
          rpt_d   = 1'b1;
          state_d = ST_RPT;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RP_W'(1);
        end
      end
      ST_RPT: begin
        if (rcnt_q == RP_W'(REPEAT_PERIOD - 1)) begin
          rpt_d  = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + RP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (toggle && level) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
      rpt_d   = 1'b0;
    end
  end
`else
  btn_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (toggle && !level) state_d = ST_HELD;
      ST_HELD: if (toggle && level)  state_d = ST_IDLE;
    endcase
  end

  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/ui_button_conditioner.sv
// N-channel button conditioner merging per-channel events into one valid/ready stream.
// Define UI_AUTOREPEAT_EN to enable auto-repeat (type 10) events.
module ui_button_conditioner
  import ui_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CH_W            = ch_width(N_BTN)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] BUTTON,
  output logic [N_BTN-1:0] LEVEL,
  output logic [N_BTN-1:0] PRESS,
  output logic [N_BTN-1:0] RELEASE,
  output logic [N_BTN-1:0] REPEAT,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [1:0]       EVT_TYPE,
  output logic [CH_W-1:0]  EVT_CH,
  output logic             OVERFLOW,
  input  logic             OVF_CLR
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    ui_btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (CLK),
      .rst_n        (RST_N),
      .button       (BUTTON[i]),
      .level        (LEVEL[i]),
      .press_pulse  (PRESS[i]),
      .release_pulse(RELEASE[i]),
      .repeat_pulse (REPEAT[i])
    );
  end

  logic [N_BTN-1:0]      pend_v, pend_v_d;
  logic [N_BTN-1:0][1:0] pend_t, pend_t_d;
  logic                  load;
  logic                  sel_found;
  logic [CH_W-1:0]       sel;
  logic                  ovf_set;

  assign load = !EVT_VALID || EVT_READY;

  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (!sel_found && pend_v[i]) begin
        sel_found = 1'b1;
        sel       = CH_W'(i);
      end
    end
  end

  // A slot taken by the output this cycle may be refilled at once without overflow.
  always_comb begin
    pend_v_d = pend_v;
    pend_t_d = pend_t;
    ovf_set  = 1'b0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (PRESS[i] || RELEASE[i] || REPEAT[i]) begin
        if (pend_v[i] && !(load && sel_found && sel == CH_W'(i))) ovf_set = 1'b1;
        pend_v_d[i] = 1'b1;
        pend_t_d[i] = REPEAT[i]  ? EVT_REPEAT :
                      RELEASE[i] ? EVT_RELEASE : EVT_PRESS;
      end else if (load && sel_found && sel == CH_W'(i)) begin
        pend_v_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_v    <= '0;
      pend_t    <= '0;
      EVT_VALID <= 1'b0;
      EVT_TYPE  <= '0;
      EVT_CH    <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      pend_v <= pend_v_d;
      pend_t <= pend_t_d;
      if (load) begin
        EVT_VALID <= sel_found;
        if (sel_found) begin
          EVT_TYPE <= pend_t[sel];
          EVT_CH   <= sel;
        end
      end
      OVERFLOW <= ovf_set || (OVERFLOW && !OVF_CLR);
    end
  end

endmodule

// File: tb/tb_ui_button_conditioner.sv
// Self-checking bench for ui_button_conditioner: vector table, directed corner cases
// and randomized stimulus against a behavioural model.
module tb_ui_button_conditioner;
  localparam int unsigned N  = 4;
  localparam int unsigned DC = 8;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 5;
`ifdef UI_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BUTTON, LEVEL, PRESS, RELEASE, REPEAT;
  logic       EVT_VALID, EVT_READY, OVERFLOW, OVF_CLR;
  logic [1:0] EVT_TYPE, EVT_CH;

  always #5 CLK = ~CLK;

  ui_button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BUTTON(BUTTON), .LEVEL(LEVEL), .PRESS(PRESS),
    .RELEASE(RELEASE), .REPEAT(REPEAT), .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
    .EVT_TYPE(EVT_TYPE), .EVT_CH(EVT_CH), .OVERFLOW(OVERFLOW), .OVF_CLR(OVF_CLR)
  );

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clean_reset();
    BUTTON = 4'hF; EVT_READY = 1'b0; OVF_CLR = 1'b0; RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [3:0]  btn;
    int unsigned cycles;
    logic [3:0]  level;
  } vec_t;
  vec_t tbl[13];

  // Behavioural model: debounced level = the last DC synchronised samples all disagree.
  logic [3:0] m_s1, m_s2, m_level, m_press, m_rel, m_rpt, m_pv;
  logic [1:0] m_pt[4];
  bit         m_hist[4][DC];
  int         m_fill[4];
  int         m_k[4];
  logic       m_ev, m_ovf;
  logic [1:0] m_ty, m_ch;

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_pv = '0;
    m_ev = 1'b0; m_ovf = 1'b0; m_ty = '0; m_ch = '0;
    for (int i = 0; i < 4; i++) begin
      m_pt[i] = '0; m_fill[i] = 0; m_k[i] = 0;
      for (int j = 0; j < DC; j++) m_hist[i][j] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] btn, input logic rdy, input logic clr);
    logic load, ovf_set, taken, tog, s, all_diff;
    int sel;
    load = !m_ev || rdy;
    sel = -1;
    for (int i = 0; i < 4; i++) if (sel < 0 && m_pv[i]) sel = i;
    if (load) begin
      if (sel >= 0) begin
        m_ev = 1'b1; m_ty = m_pt[sel]; m_ch = 2'(sel);
      end else m_ev = 1'b0;
    end
    ovf_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      taken = load && (sel == i);
      if (m_press[i] || m_rel[i] || m_rpt[i]) begin
        if (m_pv[i] && !taken) ovf_set = 1'b1;
        m_pv[i] = 1'b1;
        m_pt[i] = m_rpt[i] ? 2'b10 : (m_rel[i] ? 2'b01 : 2'b00);
      end else if (taken) m_pv[i] = 1'b0;
    end
    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    for (int i = 0; i < 4; i++) begin
      s = ~m_s2[i];
      for (int j = DC - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
      m_hist[i][0] = s;
      if (m_fill[i] < DC) m_fill[i]++;
      all_diff = (m_fill[i] == DC);
      for (int j = 0; j < DC; j++) if (m_hist[i][j] == m_level[i]) all_diff = 1'b0;
      tog = all_diff;
      m_press[i] = tog && !m_level[i];
      m_rel[i]   = tog && m_level[i];
      if (tog) m_level[i] = ~m_level[i];
      if (m_level[i]) begin
        m_k[i]   = tog ? 0 : m_k[i] + 1;
        m_rpt[i] = AR && !tog && (m_k[i] >= RD) && (((m_k[i] - RD) % RP) == 0);
      end else begin
        m_k[i] = 0; m_rpt[i] = 1'b0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = btn[i];
    end
  endtask

  initial begin
    int n, cnt, evt_rep;
    int run[4];
    logic [3:0] btn;
    logic exp_rpt;

    tbl[0]  = '{4'hF, 5, 4'h0};
    tbl[1]  = '{4'hE, 9, 4'h0};
    tbl[2]  = '{4'hE, 1, 4'h1};
    tbl[3]  = '{4'hF, 9, 4'h1};
    tbl[4]  = '{4'hF, 1, 4'h0};
    tbl[5]  = '{4'hD, 5, 4'h0};
    tbl[6]  = '{4'hF, 5, 4'h0};
    tbl[7]  = '{4'hF, 6, 4'h0};
    tbl[8]  = '{4'h6, 10, 4'h9};
    tbl[9]  = '{4'hF, 10, 4'h0};
    tbl[10] = '{4'h3, 10, 4'hC};
    tbl[11] = '{4'hA, 10, 4'h5};
    tbl[12] = '{4'hF, 10, 4'h0};

    // 1: reset and idle
    RST_N = 1'b0; BUTTON = 4'hF; EVT_READY = 1'b0; OVF_CLR = 1'b0;
    repeat (3) tick();
    chk("rst_level", LEVEL, 0);
    chk("rst_valid", EVT_VALID, 0);
    RST_N = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("idle_level", LEVEL, 0);
      chk("idle_valid", EVT_VALID, 0);
      chk("idle_ovf", OVERFLOW, 0);
    end

    // vector table
    clean_reset();
    EVT_READY = 1'b1;
    for (int t = 0; t < 13; t++) begin
      BUTTON = tbl[t].btn;
      repeat (tbl[t].cycles) tick();
      chk($sformatf("vec%0d_level", t), LEVEL, tbl[t].level);
    end

    // 2: bounce on ch1 then steady press
    clean_reset();
    for (int r = 0; r < 4; r++) begin
      BUTTON = 4'hD; repeat (5) begin tick(); chk("t2_bounce_level", LEVEL, 0); end
      BUTTON = 4'hF; repeat (5) begin tick(); chk("t2_bounce_level", LEVEL, 0); end
    end
    BUTTON = 4'hD;
    n = 0; cnt = 0;
    while (LEVEL[1] !== 1'b1 && n < 30) begin tick(); n++; if (PRESS[1]) cnt++; end
    chk("t2_latency", n, 10);
    chk("t2_press_at_rise", PRESS[1], 1);
    repeat (5) begin tick(); if (PRESS[1]) cnt++; end
    chk("t2_press_count", cnt, 1);
    chk("t2_valid", EVT_VALID, 1);
    chk("t2_ch", EVT_CH, 1);
    chk("t2_type", EVT_TYPE, 2'b00);

    // 3: simultaneous presses on ch0 and ch3
    clean_reset();
    BUTTON = 4'h6;
    n = 0;
    while (EVT_VALID !== 1'b1 && n < 30) begin tick(); n++; end
    chk("t3_evt_latency", n, 12);
    chk("t3_ch_first", EVT_CH, 0);
    chk("t3_type_first", EVT_TYPE, 2'b00);
    repeat (3) tick();
    chk("t3_hold_valid", EVT_VALID, 1);
    chk("t3_hold_ch", EVT_CH, 0);
    EVT_READY = 1'b1; tick(); EVT_READY = 1'b0;
    chk("t3_second_valid", EVT_VALID, 1);
    chk("t3_second_ch", EVT_CH, 3);
    chk("t3_second_type", EVT_TYPE, 2'b00);
    EVT_READY = 1'b1; tick(); EVT_READY = 1'b0;
    chk("t3_drained", EVT_VALID, 0);

    // 4: overwrite of a pending slot
    clean_reset();
    BUTTON = 4'hB; repeat (13) tick();
    chk("t4_ch2_loaded", EVT_CH, 2);
    BUTTON = 4'hD; repeat (12) tick();
    chk("t4_no_ovf_yet", OVERFLOW, 0);
    BUTTON = 4'hF; repeat (12) tick();
    chk("t4_ovf_set", OVERFLOW, 1);
    chk("t4_out_valid", EVT_VALID, 1);
    chk("t4_out_ch", EVT_CH, 2);
    chk("t4_out_type", EVT_TYPE, 2'b00);
    EVT_READY = 1'b1; tick(); EVT_READY = 1'b0;
    chk("t4_ev2_ch", EVT_CH, 1);
    chk("t4_ev2_type", EVT_TYPE, 2'b01);
    EVT_READY = 1'b1; tick();
    chk("t4_ev3_ch", EVT_CH, 2);
    chk("t4_ev3_type", EVT_TYPE, 2'b01);
    tick(); EVT_READY = 1'b0;
    chk("t4_drained", EVT_VALID, 0);
    chk("t4_ovf_sticky", OVERFLOW, 1);
    OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
    chk("t4_ovf_clr", OVERFLOW, 0);

    // 5: auto-repeat on a long hold of ch0
    clean_reset();
    EVT_READY = 1'b1;
    BUTTON = 4'hE;
    n = 0;
    while (LEVEL[0] !== 1'b1 && n < 30) begin tick(); n++; end
    chk("t5_rise", n, 10);
    evt_rep = 0;
    for (int off = 1; off <= 62; off++) begin
      tick();
      if (off <= 60) begin
        exp_rpt = AR && off >= RD && ((off - RD) % RP) == 0;
        chk($sformatf("t5_repeat_off%0d", off), REPEAT[0], exp_rpt);
      end
      if (off >= 3 && EVT_VALID && EVT_TYPE == 2'b10 && EVT_CH == 2'd0) evt_rep++;
    end
    chk("t5_repeat_events", evt_rep, AR ? 9 : 0);

    // 6: asynchronous reset mid-operation
    clean_reset();
    BUTTON = 4'hB; repeat (14) tick();
    chk("t6_level_pre", LEVEL[2], 1);
    chk("t6_valid_pre", EVT_VALID, 1);
    RST_N = 1'b0; #1;
    chk("t6_async_level", LEVEL, 0);
    chk("t6_async_valid", EVT_VALID, 0);
    chk("t6_async_ch", EVT_CH, 0);
    repeat (3) tick();
    RST_N = 1'b1;
    n = 0;
    while (PRESS[2] !== 1'b1 && n < 30) begin tick(); n++; end
    chk("t6_repress_latency", n, 10);

    // randomized run against the model
    clean_reset();
    model_reset();
    btn = 4'hF;
    for (int i = 0; i < 4; i++) run[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (run[i] == 0) begin
          btn[i] = 1'($urandom_range(0, 1));
          run[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 12));
        end
        run[i]--;
      end
      BUTTON = btn;
      EVT_READY = ($urandom_range(0, 3) != 0);
      OVF_CLR = ($urandom_range(0, 15) == 0);
      model_step(BUTTON, EVT_READY, OVF_CLR);
      tick();
      chk("rnd_level", LEVEL, m_level);
      chk("rnd_press", PRESS, m_press);
      chk("rnd_release", RELEASE, m_rel);
      chk("rnd_repeat", REPEAT, m_rpt);
      chk("rnd_valid", EVT_VALID, m_ev);
      chk("rnd_ovf", OVERFLOW, m_ovf);
      if (m_ev) begin
        chk("rnd_type", EVT_TYPE, m_ty);
        chk("rnd_ch", EVT_CH, m_ch);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
